pt_mem_axi_slave: RTL

//  AXI4 memory-mapped slave that holds page tables and answers the page-table walker's M00_AXI master.

---
 rtl/pt_mem_pkg.sv | 18 +
 rtl/pt_mem_ram.sv | 27 ++
 rtl/pt_mem_axi_slave.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pt_mem_pkg.sv
// pt_mem_pkg: shared AXI response codes, engine states and beat-size helper
// for the page-table memory slave.
package pt_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/pt_mem_ram.sv
// pt_mem_ram: one byte-enabled write port, one read port with registered output.
// A same-address read and write in one cycle returns the old word.
module pt_mem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int IW         = $clog2(MEM_WORDS)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [IW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pt_mem_axi_slave.sv
// pt_mem_axi_slave: AXI4 INCR-burst memory slave backing the page-table walker;
// independent read and write engines, one outstanding burst per direction.
module pt_mem_axi_slave
    import pt_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int BPB = bytes_per_beat(DATA_WIDTH);
    localparam int LB  = $clog2(BPB);
    localparam int IW  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0]   SIZE  = (ADDR_WIDTH+1)'(MEM_WORDS * BPB);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BPB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BPB - 1);

    // Borrow out of the subtraction means the address sits below BASE_ADDR.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] o;
        o = {1'b0, a} - {1'b0, BASE_ADDR};
        return !o[ADDR_WIDTH] && o < SIZE;
    endfunction

    function automatic logic [IW-1:0] word(input logic [ADDR_WIDTH-1:0] a);
        return IW'((a - BASE_ADDR) >> LB);
    endfunction

    logic                  live;
    wr_state_t             w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic                  w_slv, w_dec, w_fire, w_last, w_ok;
    rd_state_t             r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_fetch;
    logic [7:0]            r_len, r_cnt;
    logic                  r_oor, r_re, r_last;
    logic [DATA_WIDTH-1:0] ram_q;

    // Holds AxREADY low through reset and until the first edge after release.
    always_ff @(posedge ACLK or posedge ARESET)
        live <= ARESET ? 1'b0 : 1'b1;

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = live;
                if (live && S_AXI_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_last) w_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign w_fire      = S_AXI_WVALID && S_AXI_WREADY;
    assign w_last      = w_cnt == w_len;
    assign w_ok        = in_range(w_addr);
    assign S_AXI_BRESP = !S_AXI_BVALID ? OKAY : w_dec ? DECERR : w_slv ? SLVERR : OKAY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_slv   <= 1'b0;
            w_dec   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                w_addr <= S_AXI_AWADDR & ALIGN;
                w_len  <= S_AXI_AWLEN;
                w_cnt  <= '0;
                w_slv  <= 1'b0;
                w_dec  <= 1'b0;
            end
            if (w_fire) begin
                w_addr <= w_addr + STEP;
                w_cnt  <= w_cnt + 8'd1;
                if (S_AXI_WLAST != w_last) w_slv <= 1'b1;
                if (!w_ok) w_dec <= 1'b1;
            end
        end
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        r_re          = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = live;
                if (live && S_AXI_ARVALID) r_next = R_FETCH;
            end
            R_FETCH: begin
                r_re   = 1'b1;
                r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    r_re = !r_last;
                    if (r_last) r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // The RAM is addressed with the beat that will be presented next.
    assign r_last      = r_cnt == r_len;
    assign r_fetch     = r_state == R_FETCH ? r_addr : r_addr + STEP;
    assign S_AXI_RDATA = S_AXI_RVALID && !r_oor ? ram_q : '0;
    assign S_AXI_RRESP = S_AXI_RVALID && r_oor ? DECERR : OKAY;
    assign S_AXI_RLAST = S_AXI_RVALID && r_last;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                r_addr <= S_AXI_ARADDR & ALIGN;
                r_len  <= S_AXI_ARLEN;
                r_cnt  <= '0;
            end
            if (S_AXI_RVALID && S_AXI_RREADY && !r_last) begin
                r_addr <= r_fetch;
                r_cnt  <= r_cnt + 8'd1;
            end
            if (r_re) r_oor <= !in_range(r_fetch);
        end
    end

    pt_mem_ram #(.DATA_WIDTH(DATA_WIDTH), .MEM_WORDS(MEM_WORDS), .IW(IW)) u_ram (
        .clk   (ACLK),
        .we    (w_fire && w_ok),
        .waddr (word(w_addr)),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .re    (r_re),
        .raddr (word(r_fetch)),
        .rdata (ram_q)
    );

endmodule
